// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit control path: baud-select encodings,
// parity modes and the clock-to-baud divisor.
package uart_pkg;

    localparam logic [1:0] BAUD_RATE_9600  = 2'b00;
    localparam logic [1:0] BAUD_RATE_19200 = 2'b01;
    localparam logic [1:0] BAUD_RATE_38400 = 2'b10;
    localparam logic [1:0] BAUD_RATE_57600 = 2'b11;

    localparam logic PAR   = 1'b0;
    localparam logic IMPAR = 1'b1;

    // Truncating division, so 50 MHz yields 5208 / 2604 / 1302 / 868.
    function automatic logic [31:0] baud_div(input int unsigned clk_freq,
                                             input logic [1:0]  sel);
        logic [31:0] d;
        case (sel)
            BAUD_RATE_9600:  d = clk_freq / 32'd9600;
            BAUD_RATE_19200: d = clk_freq / 32'd19200;
            BAUD_RATE_38400: d = clk_freq / 32'd38400;
            default:         d = clk_freq / 32'd57600;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate generator: free-running divider producing a one-cycle tick and a
// registered square wave; any change of rate select restarts the period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_select,
    output logic       baud_tick,
    output logic       baud_clock
);

    logic [1:0]  sel_q;
    logic [31:0] count_q, count_d;
    logic [31:0] div;
    logic        baud_clock_q, baud_clock_d;
    logic        rate_change;

    always_comb begin
        div          = baud_div(CLK_FREQ, sel_q);
        rate_change  = (baud_select != sel_q);
        baud_tick    = 1'b0;
        count_d      = count_q + 32'd1;
        // A rate change abandons the current period without issuing its tick.
        if (rate_change) begin
            count_d = '0;
        end else if (count_q >= div - 32'd1) begin
            count_d   = '0;
            baud_tick = 1'b1;
        end
        baud_clock_d = (count_q < (div >> 1));
    end

    always_ff @(posedge clk) begin
        sel_q <= baud_select;
        if (rst) begin
            count_q      <= '0;
            baud_clock_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            baud_clock_q <= baud_clock_d;
        end
    end

    assign baud_clock = baud_clock_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control: baud generation, parity of the outgoing byte and
// per-tick arbitration of host requests between transmitter, FIFO and overflow.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_select,
    input  logic       parity_sel,
    input  logic [7:0] data_in,
    input  logic       in_rdy,
    input  logic       fifo_full,
    input  logic       tx_busy,
    output logic       baud_tick,
    output logic       baud_clock,
    output logic       parity,
    output logic       selected_parity,
    output logic       send_tx,
    output logic       fifo_send,
    output logic       overflow
);

    logic tick;
    logic rdy_q, rdy_d;
    logic send_tx_q, send_tx_d;
    logic fifo_send_q, fifo_send_d;
    logic overflow_q, overflow_d;
    logic req;

    uart_baud_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud_gen (
        .clk         (clk),
        .rst         (rst),
        .baud_select (baud_select),
        .baud_tick   (tick),
        .baud_clock  (baud_clock)
    );

    assign baud_tick       = tick;
    assign parity          = (parity_sel == PAR) ? ^data_in : ~^data_in;
    assign selected_parity = parity_sel;

    // Strobes are only rewritten on a tick, so each lasts one full baud period.
    always_comb begin
        rdy_d       = rdy_q;
        send_tx_d   = send_tx_q;
        fifo_send_d = fifo_send_q;
        overflow_d  = overflow_q;
        req         = 1'b0;
        if (tick) begin
            req         = in_rdy & ~rdy_q;
            rdy_d       = in_rdy;
            send_tx_d   = req & ~tx_busy;
            fifo_send_d = req & tx_busy & ~fifo_full;
            overflow_d  = overflow_q | (req & tx_busy & fifo_full);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q       <= 1'b0;
            send_tx_q   <= 1'b0;
            fifo_send_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            send_tx_q   <= send_tx_d;
            fifo_send_q <= fifo_send_d;
            overflow_q  <= overflow_d;
        end
    end

    assign send_tx   = send_tx_q;
    assign fifo_send = fifo_send_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: parity and arbitration tables plus
// hand-written sequences for baud timing, rate change, overflow and reset.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_select;
    logic       parity_sel;
    logic [7:0] data_in;
    logic       in_rdy;
    logic       fifo_full;
    logic       tx_busy;
    logic       baud_tick;
    logic       baud_clock;
    logic       parity;
    logic       selected_parity;
    logic       send_tx;
    logic       fifo_send;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    uart_tx_ctrl #(.CLK_FREQ(50_000_000)) dut (
        .clk             (clk),
        .rst             (rst),
        .baud_select     (baud_select),
        .parity_sel      (parity_sel),
        .data_in         (data_in),
        .in_rdy          (in_rdy),
        .fifo_full       (fifo_full),
        .tx_busy         (tx_busy),
        .baud_tick       (baud_tick),
        .baud_clock      (baud_clock),
        .parity          (parity),
        .selected_parity (selected_parity),
        .send_tx         (send_tx),
        .fifo_send       (fifo_send),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       sel;
        logic       exp_par;
    } par_vec_t;

    typedef struct {
        logic busy;
        logic full;
        int   exp_tx;
        int   exp_ff;
        int   exp_ovf;
    } arb_vec_t;

    par_vec_t pv[8];
    arb_vec_t av[4];

    int   m_cyc, m_tx_hi, m_tx_rise, m_ff_hi, m_ff_rise, m_both, m_first_tx, m_first_ff;
    logic m_prev_tx, m_prev_ff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns the number of rising clk edges until baud_tick is seen high.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (baud_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL tick_timeout: no tick within %0d cycles", budget);
        n = -1;
    endtask

    task automatic measure_clock(input int budget, output int hi, output int lo);
        int n;
        hi = 0;
        lo = 0;
        n  = 0;
        while (baud_clock && n < budget) begin @(negedge clk); n++; end
        while (!baud_clock && n < budget) begin @(negedge clk); n++; end
        while (baud_clock && n < budget) begin hi++; @(negedge clk); n++; end
        while (!baud_clock && n < budget) begin lo++; @(negedge clk); n++; end
    endtask

    task automatic mon_clear();
        m_cyc = 0; m_tx_hi = 0; m_tx_rise = 0; m_ff_hi = 0; m_ff_rise = 0; m_both = 0;
        m_first_tx = -1; m_first_ff = -1;
        m_prev_tx = send_tx;
        m_prev_ff = fifo_send;
    endtask

    task automatic mon_run(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            m_cyc++;
            if (send_tx) begin
                m_tx_hi++;
                if (!m_prev_tx) begin
                    m_tx_rise++;
                    if (m_first_tx < 0) m_first_tx = m_cyc;
                end
            end
            if (fifo_send) begin
                m_ff_hi++;
                if (!m_prev_ff) begin
                    m_ff_rise++;
                    if (m_first_ff < 0) m_first_ff = m_cyc;
                end
            end
            if (send_tx && fifo_send) m_both++;
            m_prev_tx = send_tx;
            m_prev_ff = fifo_send;
        end
    endtask

    // Ensures the in_rdy sample is 0, then raises in_rdy one cycle after a tick.
    task automatic start_request(input logic busy, input logic full);
        int n;
        in_rdy = 1'b0;
        wait_tick(2000, n);
        wait_tick(2000, n);
        @(negedge clk);
        tx_busy   = busy;
        fifo_full = full;
        in_rdy    = 1'b1;
    endtask

    initial begin
        int n, hi, lo;

        pv[0] = '{8'h4D, PAR,   1'b0};
        pv[1] = '{8'h4D, IMPAR, 1'b1};
        pv[2] = '{8'hB3, PAR,   1'b1};
        pv[3] = '{8'hB3, IMPAR, 1'b0};
        pv[4] = '{8'h00, PAR,   1'b0};
        pv[5] = '{8'h00, IMPAR, 1'b1};
        pv[6] = '{8'hFF, PAR,   1'b0};
        pv[7] = '{8'h01, PAR,   1'b1};

        av[0] = '{1'b0, 1'b0, 1, 0, 0};
        av[1] = '{1'b0, 1'b1, 1, 0, 0};
        av[2] = '{1'b1, 1'b0, 0, 1, 0};
        av[3] = '{1'b1, 1'b1, 0, 0, 1};

        rst = 1'b1; baud_select = BAUD_RATE_9600; parity_sel = PAR; data_in = 8'h00;
        in_rdy = 1'b0; fifo_full = 1'b0; tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_baud_tick", baud_tick, 0);
        check("rst_baud_clock", baud_clock, 0);
        check("rst_send_tx", send_tx, 0);
        check("rst_fifo_send", fifo_send, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        check("baud_clock_after_release", baud_clock, 1);

        for (int i = 0; i < 8; i++) begin
            data_in    = pv[i].data;
            parity_sel = pv[i].sel;
            #1;
            check($sformatf("parity_%02h_sel%0d", pv[i].data, pv[i].sel), parity, pv[i].exp_par);
            check($sformatf("selected_parity_%0d", i), selected_parity, pv[i].sel);
        end

        wait_tick(6000, n);
        wait_tick(6000, n);
        check("period_9600", n, 5208);
        measure_clock(20000, hi, lo);
        check("clock_high_9600", hi, 2604);
        check("clock_low_9600", lo, 2604);

        wait_tick(6000, n);
        repeat (1000) @(negedge clk);
        baud_select = BAUD_RATE_19200;
        wait_tick(6000, n);
        check("rate_change_to_19200", n, 2604);
        wait_tick(6000, n);
        check("period_19200", n, 2604);

        @(negedge clk);
        baud_select = BAUD_RATE_57600;
        wait_tick(3000, n);
        check("rate_change_to_57600", n, 868);
        wait_tick(3000, n);
        check("period_57600", n, 868);
        measure_clock(4000, hi, lo);
        check("clock_high_57600", hi, 434);
        check("clock_low_57600", lo, 434);

        for (int i = 0; i < 4; i++) begin
            start_request(av[i].busy, av[i].full);
            mon_clear();
            mon_run(3 * 868);
            in_rdy = 1'b0;
            mon_run(900);
            check($sformatf("arb%0d_send_tx_pulses", i), m_tx_rise, av[i].exp_tx);
            check($sformatf("arb%0d_send_tx_cycles", i), m_tx_hi, av[i].exp_tx * 868);
            check($sformatf("arb%0d_fifo_pulses", i), m_ff_rise, av[i].exp_ff);
            check($sformatf("arb%0d_fifo_cycles", i), m_ff_hi, av[i].exp_ff * 868);
            check($sformatf("arb%0d_both_high", i), m_both, 0);
            check($sformatf("arb%0d_overflow", i), overflow, av[i].exp_ovf);
            if (av[i].exp_tx != 0) check($sformatf("arb%0d_tx_latency", i), m_first_tx, 868);
            if (av[i].exp_ff != 0) check($sformatf("arb%0d_fifo_latency", i), m_first_ff, 868);
        end

        fifo_full = 1'b0;
        tx_busy   = 1'b0;
        wait_tick(2000, n);
        wait_tick(2000, n);
        check("overflow_sticky", overflow, 1);

        start_request(1'b0, 1'b0);
        n = 0;
        while (!send_tx && n < 2000) begin @(negedge clk); n++; end
        check("send_tx_before_reset", send_tx, 1);
        check("overflow_sticky_after_send", overflow, 1);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_send_tx", send_tx, 0);
        check("midrst_fifo_send", fifo_send, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_baud_tick", baud_tick, 0);
        check("midrst_baud_clock", baud_clock, 0);
        rst    = 1'b0;
        in_rdy = 1'b0;
        @(negedge clk);
        check("midrst_baud_clock_release", baud_clock, 1);

        wait_tick(2000, n);
        wait_tick(2000, n);
        mon_clear();
        mon_run(100);
        in_rdy = 1'b1;
        mon_run(10);
        in_rdy = 1'b0;
        mon_run(1800);
        check("short_pulse_send_tx", m_tx_rise, 0);
        check("short_pulse_fifo_send", m_ff_rise, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
